// File: rtl/kcpsm6_irq_pkg.sv
// Shared definitions for the KCPSM6 interrupt controller: default port map,
// FSM state encoding, cause/CLEAR byte bit positions and the priority encoder.
package kcpsm6_irq_pkg;

    localparam logic [7:0] PA_IRQ_CAUSE_DEF = 8'h10;
    localparam logic [7:0] PA_IRQ_MASK_DEF  = 8'h11;
    localparam logic [7:0] PA_IRQ_PEND_DEF  = 8'h12;
    localparam logic [7:0] PA_IRQ_CLEAR_DEF = 8'h13;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_SERVICE = 2'd2
    } irq_state_e;

    localparam int CAUSE_WDOG_BIT  = 7;
    localparam int CAUSE_OVR_BIT   = 6;
    localparam int CAUSE_INSVC_BIT = 3;

    localparam int CLR_WDOG_BIT = 7;
    localparam int CLR_OVR_BIT  = 6;

    // Lowest set index wins, so the tick (bit 0) has top priority.
    function automatic logic [2:0] lowest_set(input logic [7:0] v);
        lowest_set = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) lowest_set = 3'(i);
        end
    endfunction

endpackage

// File: rtl/kcpsm6_irq_ctrl_if.sv
// KCPSM6 port-I/O and interrupt handshake bundle; master is the processor
// side, slave is the interrupt controller.
interface kcpsm6_irq_ctrl_if;
    logic [7:0] port_id;
    logic [7:0] out_port;
    logic       write_strobe;
    logic       k_write_strobe;
    logic       read_strobe;
    logic       interrupt_ack;
    logic       interrupt;
    logic [7:0] rd_data;
    logic       rd_hit;

    modport master (
        output port_id, out_port, write_strobe, k_write_strobe, read_strobe, interrupt_ack,
        input  interrupt, rd_data, rd_hit
    );

    modport slave (
        input  port_id, out_port, write_strobe, k_write_strobe, read_strobe, interrupt_ack,
        output interrupt, rd_data, rd_hit
    );
endinterface

// File: rtl/irq_edge_pend.sv
// Rising-edge detect and pending latch for the external interrupt sources;
// a new edge beats a same-cycle clear, and an edge onto a set bit flags overrun.
module irq_edge_pend #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] src,
    input  logic [W-1:0] clr,
    output logic [W-1:0] pend,
    output logic         ovr_evt
);

    logic [W-1:0] src_q, src_d;
    logic [W-1:0] pend_q, pend_d;
    logic [W-1:0] rise;

    always_comb begin
        src_d  = src;
        rise   = src & ~src_q;
        pend_d = (pend_q & ~clr) | rise;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            src_q  <= '0;
            pend_q <= '0;
        end else begin
            src_q  <= src_d;
            pend_q <= pend_d;
        end
    end

    assign pend    = pend_q;
    assign ovr_evt = |(rise & pend_q);

endmodule

// File: rtl/kcpsm6_irq_ctrl.sv
// Prioritised interrupt controller for KCPSM6: 100 Hz tick plus external
// sources, mask/pending/cause registers, explicit CLEAR end-of-service.
// Optional service watchdog enabled by defining IRQ_WATCHDOG_EN.
module kcpsm6_irq_ctrl
    import kcpsm6_irq_pkg::*;
#(
    parameter int         NUM_SRC      = 4,
    parameter int         TICK_DIV     = 1000000,
    parameter logic [7:0] PA_IRQ_CAUSE = PA_IRQ_CAUSE_DEF,
    parameter logic [7:0] PA_IRQ_MASK  = PA_IRQ_MASK_DEF,
    parameter logic [7:0] PA_IRQ_PEND  = PA_IRQ_PEND_DEF,
    parameter logic [7:0] PA_IRQ_CLEAR = PA_IRQ_CLEAR_DEF,
    parameter int         WDOG_CYCLES  = 2000000
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_SRC-2:0] irq_src,
    output logic               tick_100hz,
    kcpsm6_irq_ctrl_if.slave   bus
);

    localparam int TICK_W = $clog2(TICK_DIV + 1);

    logic [TICK_W-1:0]  tick_cnt_q, tick_cnt_d;
    logic               tick_hit;
    logic               tick_q, tick_d;
    irq_state_e         state_q, state_d;
    logic [2:0]         cause_q, cause_d;
    logic [7:0]         mask_q, mask_d;
    logic               pend0_q, pend0_d;
    logic               ovr_q, ovr_d;
    logic               wdog_q, wdog_d;
    logic [7:0]         rd_data_q, rd_data_d;
    logic               rd_hit_q, rd_hit_d;
    logic [NUM_SRC-2:0] ext_pend;
    logic               ext_ovr;
    logic [7:0]         pending, masked, clr_vec, cause_byte;
    logic               wr_en, mask_wr, clr_wr, ack_clr, wdog_expired, wdog_set;
    logic               unused_bus;

    assign unused_bus = &{1'b0, bus.read_strobe, bus.out_port};

    assign wr_en   = bus.write_strobe | bus.k_write_strobe;
    assign mask_wr = wr_en && (bus.port_id == PA_IRQ_MASK);
    assign clr_wr  = wr_en && (bus.port_id == PA_IRQ_CLEAR);
    assign ack_clr = (state_q == ST_ASSERT) && bus.interrupt_ack;
    assign clr_vec = ack_clr ? (8'h01 << cause_q) : 8'h00;

    irq_edge_pend #(.W(NUM_SRC - 1)) u_edge_pend (
        .clk     (clk),
        .reset_n (reset_n),
        .src     (irq_src),
        .clr     (clr_vec[NUM_SRC-1:1]),
        .pend    (ext_pend),
        .ovr_evt (ext_ovr)
    );

`ifdef IRQ_WATCHDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
    logic [WDOG_W-1:0] wdog_cnt_q, wdog_cnt_d;

    // Counter sits at zero outside SERVICE, so entering SERVICE starts a fresh count.
    always_comb begin
        wdog_cnt_d   = '0;
        wdog_expired = 1'b0;
        if (state_q == ST_SERVICE) begin
            wdog_cnt_d   = wdog_cnt_q + 1'b1;
            wdog_expired = (wdog_cnt_q == WDOG_W'(WDOG_CYCLES - 1));
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) wdog_cnt_q <= '0;
        else          wdog_cnt_q <= wdog_cnt_d;
    end
`else
    localparam int unused_wdog_cycles = WDOG_CYCLES;
    assign wdog_expired = 1'b0;
`endif

    always_comb begin
        tick_hit   = (tick_cnt_q == TICK_W'(TICK_DIV - 1));
        tick_cnt_d = tick_hit ? '0 : tick_cnt_q + 1'b1;
        tick_d     = tick_hit;
        pend0_d    = (pend0_q & ~clr_vec[0]) | tick_hit;

        pending              = '0;
        pending[0]           = pend0_q;
        pending[NUM_SRC-1:1] = ext_pend;
        masked               = pending & mask_q;

        mask_d = mask_q;
        if (mask_wr) begin
            mask_d              = '0;
            mask_d[NUM_SRC-1:0] = bus.out_port[NUM_SRC-1:0];
        end
    end

    always_comb begin
        state_d  = state_q;
        cause_d  = cause_q;
        wdog_set = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|masked) begin
                    cause_d = lowest_set(masked);
                    state_d = ST_ASSERT;
                end
            end
            ST_ASSERT: begin
                if (bus.interrupt_ack) state_d = ST_SERVICE;
            end
            ST_SERVICE: begin
                if (clr_wr) begin
                    state_d = ST_IDLE;
                end else if (wdog_expired) begin
                    state_d  = ST_IDLE;
                    wdog_set = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Sticky flags: a new event in the same cycle as its clear is kept.
        ovr_d  = (ovr_q & ~(clr_wr & bus.out_port[CLR_OVR_BIT])) | ext_ovr;
        wdog_d = (wdog_q & ~(clr_wr & bus.out_port[CLR_WDOG_BIT])) | wdog_set;
    end

    always_comb begin
        cause_byte                  = '0;
        cause_byte[CAUSE_WDOG_BIT]  = wdog_q;
        cause_byte[CAUSE_OVR_BIT]   = ovr_q;
        cause_byte[CAUSE_INSVC_BIT] = (state_q != ST_IDLE);
        cause_byte[2:0]             = cause_q;

        rd_hit_d  = 1'b1;
        rd_data_d = '0;
        if (bus.port_id == PA_IRQ_CAUSE)     rd_data_d = cause_byte;
        else if (bus.port_id == PA_IRQ_MASK) rd_data_d = mask_q;
        else if (bus.port_id == PA_IRQ_PEND) rd_data_d = pending;
        else                                 rd_hit_d  = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tick_cnt_q <= '0;
            tick_q     <= 1'b0;
            state_q    <= ST_IDLE;
            cause_q    <= '0;
            mask_q     <= 8'h01;
            pend0_q    <= 1'b0;
            ovr_q      <= 1'b0;
            wdog_q     <= 1'b0;
            rd_data_q  <= '0;
            rd_hit_q   <= 1'b0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            tick_q     <= tick_d;
            state_q    <= state_d;
            cause_q    <= cause_d;
            mask_q     <= mask_d;
            pend0_q    <= pend0_d;
            ovr_q      <= ovr_d;
            wdog_q     <= wdog_d;
            rd_data_q  <= rd_data_d;
            rd_hit_q   <= rd_hit_d;
        end
    end

    assign bus.interrupt = (state_q == ST_ASSERT);
    assign bus.rd_data   = rd_data_q;
    assign bus.rd_hit    = rd_hit_q;
    assign tick_100hz    = tick_q;

endmodule
